// File: rtl/ula_pkg.sv
// Shared types for the multi-cycle ULA: opcode encoding, FSM states and the
// helper that tells which opcodes need the iterative unit.
package ula_pkg;

   typedef enum logic [3:0] {
      ADD  = 4'd0,
      SUB  = 4'd1,
      AND  = 4'd2,
      OR   = 4'd3,
      XOR  = 4'd4,
      SLT  = 4'd5,
      SLTU = 4'd6,
      SLL  = 4'd7,
      SRL  = 4'd8,
      SRA  = 4'd9,
      MUL  = 4'd10,
      DIVU = 4'd11,
      REMU = 4'd12
   } ula_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic is_multicycle(input ula_op_t op);
      return (op == MUL) || (op == DIVU) || (op == REMU);
   endfunction

endpackage

// File: rtl/ula_mc_iter.sv
// Iterative shift-add multiplier and restoring divider sharing one WIDTH+1 bit
// adder. One bit per cycle; done/result show the outcome of the final step.
module ula_mc_iter
   import ula_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  ula_op_t          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   ula_op_t          op_r;
   logic             busy;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc;   // partial product, or partial remainder
   logic [WIDTH-1:0] breg;  // shifting multiplicand, or divisor
   logic [WIDTH-1:0] qm;    // shifting multiplier, or dividend/quotient

   logic             is_mul;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   add_x;
   logic [WIDTH:0]   add_y;
   logic [WIDTH:0]   sum;
   logic             fits;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] qm_div_next;

   assign is_mul = (op_r == MUL);
   assign rem_sh = {acc, qm[WIDTH-1]};

   // Divide uses x + ~y + 1 on the same adder that accumulates the product.
   assign add_x = is_mul ? {1'b0, acc} : rem_sh;
   assign add_y = is_mul ? {1'b0, (qm[0] ? breg : {WIDTH{1'b0}})} : ~{1'b0, breg};
   assign sum   = add_x + add_y + {{WIDTH{1'b0}}, ~is_mul};

   // sum[WIDTH] set means the trial subtraction went negative: restore.
   assign fits        = ~sum[WIDTH];
   assign acc_next    = (is_mul || fits) ? sum[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   assign qm_div_next = {qm[WIDTH-2:0], fits};

   assign done   = busy && (cnt == CNT_W'(WIDTH - 1));
   assign result = (op_r == DIVU) ? qm_div_next : acc_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r <= ADD;
         busy <= 1'b0;
         cnt  <= '0;
         acc  <= '0;
         breg <= '0;
         qm   <= '0;
      end else if (start) begin
         op_r <= op;
         busy <= 1'b1;
         cnt  <= '0;
         acc  <= '0;
         breg <= (op == MUL) ? a : b;
         qm   <= (op == MUL) ? b : a;
      end else if (busy) begin
         acc  <= acc_next;
         cnt  <= cnt + 1'b1;
         if (is_mul) begin
            breg <= breg << 1;
            qm   <= qm >> 1;
         end else begin
            qm   <= qm_div_next;
         end
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/ula_mc.sv
// Multi-cycle ULA: control FSM, single-cycle combinational ops and registered
// result/flags behind valid/ready handshakes on both sides.
module ula_mc
   import ula_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [3:0]       ULAcontrol,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ULAresult,
   output logic             Z,
   output logic             V,
   output logic             DZ,
   output state_t           fsm_state
);

   // Handshake: a transfer happens on a rising edge where valid && ready;
   // valid never drops and data never changes until that transfer.

   localparam int SH_W = $clog2(WIDTH);

   ula_op_t          op;
   logic             accept;
   logic             div_zero;
   logic             iter_start;
   logic             iter_done;
   logic [WIDTH-1:0] iter_result;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_res;
   logic [SH_W-1:0]  shamt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_v;
   state_t           state;

   assign op         = ula_op_t'(ULAcontrol);
   assign accept     = in_valid && in_ready;
   assign div_zero   = (op == DIVU || op == REMU) && (SrcB == '0);
   assign iter_start = (state == IDLE) && accept && is_multicycle(op) && !div_zero;
   assign shamt      = SrcB[SH_W-1:0];

   assign add_b   = (op == SUB) ? ~SrcB : SrcB;
   assign add_res = SrcA + add_b + {{(WIDTH-1){1'b0}}, (op == SUB)};

   always_comb begin
      alu_res = '0;
      alu_v   = 1'b0;
      case (op)
         ADD, SUB: begin
            alu_res = add_res;
            alu_v   = (SrcA[WIDTH-1] == add_b[WIDTH-1]) && (add_res[WIDTH-1] != SrcA[WIDTH-1]);
         end
         AND:  alu_res = SrcA & SrcB;
         OR:   alu_res = SrcA | SrcB;
         XOR:  alu_res = SrcA ^ SrcB;
         SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         SLTU: alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
         SLL:  alu_res = SrcA << shamt;
         SRL:  alu_res = SrcA >> shamt;
         SRA:  alu_res = WIDTH'($signed(SrcA) >>> shamt);
         default: alu_res = '0;
      endcase
   end

   ula_mc_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (iter_start),
      .op     (op),
      .a      (SrcA),
      .b      (SrcB),
      .done   (iter_done),
      .result (iter_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         ULAresult <= '0;
         V         <= 1'b0;
         DZ        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  in_ready <= 1'b0;
                  if (div_zero) begin
                     ULAresult <= (op == DIVU) ? {WIDTH{1'b1}} : SrcA;
                     V         <= 1'b0;
                     DZ        <= 1'b1;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else if (is_multicycle(op)) begin
                     state     <= EXEC;
                  end else begin
                     ULAresult <= alu_res;
                     V         <= alu_v;
                     DZ        <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            EXEC: begin
               if (iter_done) begin
                  ULAresult <= iter_result;
                  V         <= 1'b0;
                  DZ        <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign Z         = (ULAresult == '0);
   assign fsm_state = state;

endmodule

// File: tb/tb_ula_mc.sv
// Directed-vector bench for ula_mc (WIDTH=32) with hand-computed expectations.
module tb_ula_mc;
   import ula_pkg::*;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] SrcA;
   logic [W-1:0] SrcB;
   logic [3:0]   ULAcontrol;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] ULAresult;
   logic         Z;
   logic         V;
   logic         DZ;
   state_t       fsm_state;

   int n_cmp;
   int n_bad;

   ula_mc #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .ULAcontrol (ULAcontrol),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ULAresult  (ULAresult),
      .Z          (Z),
      .V          (V),
      .DZ         (DZ),
      .fsm_state  (fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one request, measure latency, check result/flags, then complete the
   // handshake after hold cycles of backpressure (with a stray request pulse).
   task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res,
                        input logic exp_v, input logic exp_dz, input int exp_lat,
                        input int hold);
      int lat;
      out_ready  = (hold == 0);
      check({tag, "_rdy"}, W'(in_ready), W'(1));
      in_valid   = 1'b1;
      ULAcontrol = op;
      SrcA       = a;
      SrcB       = b;
      @(posedge clk); #1;
      in_valid   = 1'b0;
      SrcA       = $urandom;
      SrcB       = $urandom;
      lat = 1;
      while (!out_valid && lat < 100) begin
         check({tag, "_busy"}, W'(in_ready), W'(0));
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, W'(lat), W'(exp_lat));
      check({tag, "_res"}, ULAresult, exp_res);
      check({tag, "_z"}, W'(Z), W'(exp_res == '0));
      check({tag, "_v"}, W'(V), W'(exp_v));
      check({tag, "_dz"}, W'(DZ), W'(exp_dz));
      for (int i = 0; i < hold; i++) begin
         in_valid   = (i == 1);
         ULAcontrol = 4'd0;
         SrcA       = 32'd1;
         SrcB       = 32'd1;
         @(posedge clk); #1;
         check({tag, "_hold_vld"}, W'(out_valid), W'(1));
         check({tag, "_hold_res"}, ULAresult, exp_res);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, "_end_vld"}, W'(out_valid), W'(0));
      check({tag, "_end_rdy"}, W'(in_ready), W'(1));
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      SrcA = '0;
      SrcB = '0;
      ULAcontrol = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_res", ULAresult, 32'h0);
      check("rst_z", W'(Z), W'(1));
      check("rst_v", W'(V), W'(0));
      check("rst_dz", W'(DZ), W'(0));
      check("rst_ovld", W'(out_valid), W'(0));
      check("rst_rdy", W'(in_ready), W'(1));
      check("rst_state", W'(fsm_state), W'(IDLE));
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op("add_ovf", 4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1, 0);
      do_op("sub_zero", 4'd1, 32'd5, 32'd5, 32'h0, 1'b0, 1'b0, 1, 0);
      do_op("sub_ovf", 4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1, 0);
      do_op("slt", 4'd5,      32'hFFFFFFFF, 32'h00000001, 32'h1, 1'b0, 1'b0, 1, 0);
      do_op("sltu", 4'd6,     32'hFFFFFFFF, 32'h00000001, 32'h0, 1'b0, 1'b0, 1, 0);
      do_op("and", 4'd2,      32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1, 0);
      do_op("or", 4'd3,       32'hF0F0F0F0, 32'h0F000F00, 32'hFFF0FFF0, 1'b0, 1'b0, 1, 0);
      do_op("xor", 4'd4,      32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0, 1, 0);
      do_op("sll", 4'd7,      32'h00000001, 32'h0000003F, 32'h80000000, 1'b0, 1'b0, 1, 0);
      do_op("srl", 4'd8,      32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 1, 0);
      do_op("sra0", 4'd9,     32'h9ABCDEF0, 32'h00000020, 32'h9ABCDEF0, 1'b0, 1'b0, 1, 0);
      do_op("illegal", 4'd13, 32'h12345678, 32'h1, 32'h0, 1'b0, 1'b0, 1, 0);
      do_op("mul", 4'd10,     32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 1'b0, 33, 0);
      do_op("mul_max", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 33, 0);
      do_op("divu", 4'd11,    32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33, 0);
      do_op("remu", 4'd12,    32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33, 0);
      do_op("divu_max", 4'd11, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 1'b0, 1'b0, 33, 0);
      do_op("remu_16", 4'd12, 32'hFFFFFFFF, 32'h10, 32'hF, 1'b0, 1'b0, 33, 0);
      do_op("divu_dz", 4'd11, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1, 0);
      do_op("remu_dz", 4'd12, 32'd9, 32'd0, 32'd9, 1'b0, 1'b1, 1, 0);
      do_op("sra_bp", 4'd9,   32'h80000000, 32'h4, 32'hF8000000, 1'b0, 1'b0, 1, 5);
      do_op("after_bp", 4'd0, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1, 0);

      // Abort a multiply mid-flight with an asynchronous reset.
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      ULAcontrol = 4'd10;
      SrcA       = 32'h0000FFFF;
      SrcB       = 32'h00010001;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("mid_state", W'(fsm_state), W'(EXEC));
      rst_n = 1'b0;
      #1;
      check("abort_ovld", W'(out_valid), W'(0));
      check("abort_rdy", W'(in_ready), W'(1));
      check("abort_res", ULAresult, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_ovld", W'(out_valid), W'(0));
      do_op("add_post_rst", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
